// File: rtl/z80_ir_iff_unit_pkg.sv
// Shared Z80 definitions for the I/R/IFF unit: flag bit positions,
// LD A,I/R source encoding and the flag-result helper.
package z80_ir_iff_unit_pkg;

  localparam int unsigned FLAG_C_BIT  = 0;
  localparam int unsigned FLAG_N_BIT  = 1;
  localparam int unsigned FLAG_PV_BIT = 2;
  localparam int unsigned FLAG_X_BIT  = 3;
  localparam int unsigned FLAG_H_BIT  = 4;
  localparam int unsigned FLAG_Y_BIT  = 5;
  localparam int unsigned FLAG_Z_BIT  = 6;
  localparam int unsigned FLAG_S_BIT  = 7;

  // Bits of F that LD A,I/R passes through unchanged (5, 3 and C).
  localparam logic [7:0] F_KEEP_MASK =
    8'((1 << FLAG_Y_BIT) | (1 << FLAG_X_BIT) | (1 << FLAG_C_BIT));

  // Which register an LD A,x strobe reads this cycle.
  typedef enum logic [1:0] {
    LDA_NONE   = 2'd0,
    LDA_FROM_I = 2'd1,
    LDA_FROM_R = 2'd2
  } lda_src_e;

  // F after LD A,I / LD A,R: S,Z from the value, H=N=0, P/V supplied.
  function automatic logic [7:0] lda_flags(input logic [7:0] src,
                                           input logic [7:0] f_in,
                                           input logic       pv);
    logic [7:0] f;
    f              = f_in & F_KEEP_MASK;
    f[FLAG_S_BIT]  = src[7];
    f[FLAG_Z_BIT]  = (src == 8'h00);
    f[FLAG_PV_BIT] = pv;
    return f;
  endfunction

endpackage

// File: rtl/z80_ir_iff_unit_if.sv
// Decoder-side strobes and result bus of the I/R/IFF unit.
interface z80_ir_iff_unit_if;
  logic       m1_fetch;
  logic       insn_done;
  logic       ld_i_a;
  logic       ld_r_a;
  logic       ld_a_i;
  logic       ld_a_r;
  logic [7:0] a_in;
  logic [7:0] f_in;
  logic       ei;
  logic       di;
  logic       retn;
  logic       nmi_ack;
  logic       int_ack;
  logic [7:0] reg_i;
  logic [7:0] reg_r;
  logic       iff1;
  logic       iff2;
  logic       int_enable;
  logic       af_valid;
  logic [7:0] a_out;
  logic [7:0] f_out;

  modport master (
    output m1_fetch, insn_done, ld_i_a, ld_r_a, ld_a_i, ld_a_r,
           a_in, f_in, ei, di, retn, nmi_ack, int_ack,
    input  reg_i, reg_r, iff1, iff2, int_enable, af_valid, a_out, f_out
  );

  modport slave (
    input  m1_fetch, insn_done, ld_i_a, ld_r_a, ld_a_i, ld_a_r,
           a_in, f_in, ei, di, retn, nmi_ack, int_ack,
    output reg_i, reg_r, iff1, iff2, int_enable, af_valid, a_out, f_out
  );
endinterface

// File: rtl/z80_refresh_counter.sv
// Z80 R register: low R_COUNT_BITS count opcode fetches, upper bits held,
// LD R,A load overrides the increment. r_next is the post-update value.
module z80_refresh_counter #(
  parameter int unsigned R_COUNT_BITS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] r,
  output logic [7:0] r_next
);

  // Mask form avoids a zero-width upper slice when all 8 bits count.
  localparam logic [7:0] CNT_MASK = 8'((9'd1 << R_COUNT_BITS) - 9'd1);

  logic [7:0] r_q;

  // Next R: load wins over increment; increment wraps inside the mask.
  always_comb begin
    r_next = r_q;
    if (load) begin
      r_next = load_val;
    end else if (inc) begin
      r_next = (r_q & ~CNT_MASK) | ((r_q + 8'd1) & CNT_MASK);
    end
  end

  // R register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_next;
    end
  end

  assign r = r_q;

endmodule

// File: rtl/z80_ir_iff_unit.sv
// Z80 I and R registers, IFF1/IFF2 with EI shadow, and the A/F results
// of LD A,I and LD A,R.
module z80_ir_iff_unit
  import z80_ir_iff_unit_pkg::*;
#(
  parameter int unsigned R_COUNT_BITS  = 7,
  parameter bit          NMOS_PV_QUIRK = 1'b0,
  parameter logic [7:0]  RESET_I       = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  z80_ir_iff_unit_if.slave   bus
);

  logic [7:0] reg_i_q;
  logic [7:0] reg_i_next;
  logic [7:0] r_q;
  logic [7:0] r_next;
  logic       iff1_q;
  logic       iff2_q;
  logic       ei_shadow_q;
  logic       af_valid_q;
  logic [7:0] a_out_q;
  logic [7:0] f_out_q;
  lda_src_e   lda_src;
  logic [7:0] lda_val;
  logic       pv_bit;

  z80_refresh_counter #(
    .R_COUNT_BITS(R_COUNT_BITS)
  ) u_refresh (
    .clk      (clk),
    .reset    (reset),
    .inc      (bus.m1_fetch),
    .load     (bus.ld_r_a),
    .load_val (bus.a_in),
    .r        (r_q),
    .r_next   (r_next)
  );

  // Post-update I for same-cycle LD I,A then LD A,I reads.
  always_comb begin
    reg_i_next = reg_i_q;
    if (bus.ld_i_a) begin
      reg_i_next = bus.a_in;
    end
  end

  // I register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_i_q <= RESET_I;
    end else begin
      reg_i_q <= reg_i_next;
    end
  end

  // Select LD A,x source (R wins on conflict) and build P/V from pre-update IFF2.
  always_comb begin
    lda_src = LDA_NONE;
    if (bus.ld_a_r) begin
      lda_src = LDA_FROM_R;
    end else if (bus.ld_a_i) begin
      lda_src = LDA_FROM_I;
    end
    lda_val = (lda_src == LDA_FROM_R) ? r_next : reg_i_next;
    pv_bit  = iff2_q & ~(NMOS_PV_QUIRK & (bus.int_ack | bus.nmi_ack));
  end

  // Registered LD A,I/R result with a one-cycle valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_valid_q <= 1'b0;
      a_out_q    <= '0;
      f_out_q    <= '0;
    end else begin
      af_valid_q <= (lda_src != LDA_NONE);
      if (lda_src != LDA_NONE) begin
        a_out_q <= lda_val;
        f_out_q <= lda_flags(lda_val, bus.f_in, pv_bit);
      end
    end
  end

  // Interrupt flip-flops and EI shadow, acknowledges taking priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iff1_q      <= 1'b0;
      iff2_q      <= 1'b0;
      ei_shadow_q <= 1'b0;
    end else if (bus.nmi_ack) begin
      iff1_q      <= 1'b0;
      ei_shadow_q <= 1'b0;
    end else if (bus.int_ack) begin
      iff1_q      <= 1'b0;
      iff2_q      <= 1'b0;
      ei_shadow_q <= 1'b0;
    end else if (bus.di) begin
      iff1_q      <= 1'b0;
      iff2_q      <= 1'b0;
      ei_shadow_q <= 1'b0;
    end else if (bus.ei) begin
      iff1_q      <= 1'b1;
      iff2_q      <= 1'b1;
      ei_shadow_q <= 1'b1;
    end else begin
      if (bus.retn) begin
        iff1_q <= iff2_q;
      end
      // A retiring instruction other than EI closes the shadow.
      if (bus.insn_done) begin
        ei_shadow_q <= 1'b0;
      end
    end
  end

  assign bus.reg_i      = reg_i_q;
  assign bus.reg_r      = r_q;
  assign bus.iff1       = iff1_q;
  assign bus.iff2       = iff2_q;
  assign bus.int_enable = iff1_q & ~ei_shadow_q;
  assign bus.af_valid   = af_valid_q;
  assign bus.a_out      = a_out_q;
  assign bus.f_out      = f_out_q;

  a_lda_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(bus.ld_a_i && bus.ld_a_r));

  a_iff_cmd_exclusive: assert property (@(posedge clk) disable iff (reset)
    $onehot0({bus.ei, bus.di, bus.retn}));

endmodule

// File: tb/tb_z80_ir_iff_unit.sv
// Self-checking bench for z80_ir_iff_unit: two instances differing only in
// NMOS_PV_QUIRK share stimulus; LD A,x results go through scoreboards.
module tb_z80_ir_iff_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  z80_ir_iff_unit_if bus_a ();
  z80_ir_iff_unit_if bus_b ();

  assign bus_b.m1_fetch  = bus_a.m1_fetch;
  assign bus_b.insn_done = bus_a.insn_done;
  assign bus_b.ld_i_a    = bus_a.ld_i_a;
  assign bus_b.ld_r_a    = bus_a.ld_r_a;
  assign bus_b.ld_a_i    = bus_a.ld_a_i;
  assign bus_b.ld_a_r    = bus_a.ld_a_r;
  assign bus_b.a_in      = bus_a.a_in;
  assign bus_b.f_in      = bus_a.f_in;
  assign bus_b.ei        = bus_a.ei;
  assign bus_b.di        = bus_a.di;
  assign bus_b.retn      = bus_a.retn;
  assign bus_b.nmi_ack   = bus_a.nmi_ack;
  assign bus_b.int_ack   = bus_a.int_ack;

  z80_ir_iff_unit #(
    .R_COUNT_BITS  (7),
    .NMOS_PV_QUIRK (1'b0),
    .RESET_I       (8'h00)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  z80_ir_iff_unit #(
    .R_COUNT_BITS  (7),
    .NMOS_PV_QUIRK (1'b1),
    .RESET_I       (8'h00)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_strobes();
    bus_a.m1_fetch  = 1'b0;
    bus_a.insn_done = 1'b0;
    bus_a.ld_i_a    = 1'b0;
    bus_a.ld_r_a    = 1'b0;
    bus_a.ld_a_i    = 1'b0;
    bus_a.ld_a_r    = 1'b0;
    bus_a.ei        = 1'b0;
    bus_a.di        = 1'b0;
    bus_a.retn      = 1'b0;
    bus_a.nmi_ack   = 1'b0;
    bus_a.int_ack   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    step();
    clear_strobes();
  endtask

  task automatic expect_af(input logic [7:0] a, input logic [7:0] fa, input logic [7:0] fb);
    q_a.push_back({a, fa});
    q_b.push_back({a, fb});
  endtask

  // Scoreboard monitor for the quirk-off instance.
  always @(negedge clk) begin
    if (!reset && bus_a.af_valid) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL af_valid_a: unexpected pulse a_out=%h f_out=%h", bus_a.a_out, bus_a.f_out);
      end else begin
        logic [15:0] e;
        e = q_a.pop_front();
        check("a_out_a", bus_a.a_out, e[15:8]);
        check("f_out_a", bus_a.f_out, e[7:0]);
      end
    end
  end

  // Scoreboard monitor for the quirk-on instance.
  always @(negedge clk) begin
    if (!reset && bus_b.af_valid) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL af_valid_b: unexpected pulse a_out=%h f_out=%h", bus_b.a_out, bus_b.f_out);
      end else begin
        logic [15:0] e;
        e = q_b.pop_front();
        check("a_out_b", bus_b.a_out, e[15:8]);
        check("f_out_b", bus_b.f_out, e[7:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus_a.a_in = 8'h00;
    bus_a.f_in = 8'h00;
    clear_strobes();
    step();
    step();
    check("rst_reg_i", bus_a.reg_i, 8'h00);
    check("rst_reg_r", bus_a.reg_r, 8'h00);
    check("rst_iff1", {7'd0, bus_a.iff1}, 8'h00);
    check("rst_iff2", {7'd0, bus_a.iff2}, 8'h00);
    check("rst_int_enable", {7'd0, bus_a.int_enable}, 8'h00);
    check("rst_af_valid", {7'd0, bus_a.af_valid}, 8'h00);
    check("rst_a_out", bus_a.a_out, 8'h00);
    check("rst_f_out", bus_a.f_out, 8'h00);
    reset = 1'b0;
    step();

    // 130 fetches with a 7-bit counter wrap to 2.
    bus_a.m1_fetch = 1'b1;
    repeat (130) step();
    clear_strobes();
    check("r_after_130", bus_a.reg_r, 8'h02);

    // Wrap keeps bit 7.
    bus_a.ld_r_a = 1'b1; bus_a.a_in = 8'hFF; cycle();
    check("r_load_ff", bus_a.reg_r, 8'hFF);
    bus_a.m1_fetch = 1'b1; cycle();
    check("r_wrap_80", bus_a.reg_r, 8'h80);

    // Load overrides same-cycle fetch.
    bus_a.ld_r_a = 1'b1; bus_a.m1_fetch = 1'b1; bus_a.a_in = 8'h7F; cycle();
    check("r_load_over_fetch", bus_a.reg_r, 8'h7F);
    bus_a.ld_a_r = 1'b1; bus_a.f_in = 8'hFF;
    expect_af(8'h7F, 8'h29, 8'h29);
    cycle();
    // Same-cycle fetch: 7F -> 00 in the low 7 bits, Z set.
    bus_a.ld_a_r = 1'b1; bus_a.m1_fetch = 1'b1;
    expect_af(8'h00, 8'h69, 8'h69);
    cycle();
    check("r_wrap_00", bus_a.reg_r, 8'h00);

    // LD I,A then LD A,I with negative value.
    bus_a.ld_i_a = 1'b1; bus_a.a_in = 8'hA5; cycle();
    check("i_load_a5", bus_a.reg_i, 8'hA5);
    bus_a.ld_a_i = 1'b1; bus_a.f_in = 8'h00;
    expect_af(8'hA5, 8'h80, 8'h80);
    cycle();
    bus_a.ld_i_a = 1'b1; bus_a.a_in = 8'h00; cycle();

    // EI then LD A,I: P/V=1, Z=1, shadow held until a plain retire.
    bus_a.ei = 1'b1; bus_a.insn_done = 1'b1; cycle();
    check("ei_iff1", {7'd0, bus_a.iff1}, 8'h01);
    check("ei_iff2", {7'd0, bus_a.iff2}, 8'h01);
    check("ei_shadow_ie", {7'd0, bus_a.int_enable}, 8'h00);
    bus_a.ld_a_i = 1'b1; bus_a.f_in = 8'hFF;
    expect_af(8'h00, 8'h6D, 8'h6D);
    cycle();
    check("af_valid_hi", {7'd0, bus_a.af_valid}, 8'h01);
    check("shadow_no_retire_ie", {7'd0, bus_a.int_enable}, 8'h00);
    step();
    check("af_valid_lo", {7'd0, bus_a.af_valid}, 8'h00);
    bus_a.insn_done = 1'b1; cycle();
    check("ie_after_retire", {7'd0, bus_a.int_enable}, 8'h01);

    // Consecutive EIs extend the shadow.
    bus_a.ei = 1'b1; bus_a.insn_done = 1'b1; cycle();
    check("ei1_ie", {7'd0, bus_a.int_enable}, 8'h00);
    bus_a.ei = 1'b1; bus_a.insn_done = 1'b1; cycle();
    check("ei2_ie", {7'd0, bus_a.int_enable}, 8'h00);
    bus_a.insn_done = 1'b1; cycle();
    check("ei_ei_done_ie", {7'd0, bus_a.int_enable}, 8'h01);

    // NMI / RETN / INT sequencing.
    bus_a.nmi_ack = 1'b1; cycle();
    check("nmi_iff1", {7'd0, bus_a.iff1}, 8'h00);
    check("nmi_iff2", {7'd0, bus_a.iff2}, 8'h01);
    bus_a.retn = 1'b1; cycle();
    check("retn_iff1", {7'd0, bus_a.iff1}, 8'h01);
    bus_a.int_ack = 1'b1; cycle();
    check("int_iff1", {7'd0, bus_a.iff1}, 8'h00);
    check("int_iff2", {7'd0, bus_a.iff2}, 8'h00);

    // P/V quirk: LD A,R with int_ack, then with nmi_ack.
    bus_a.ld_r_a = 1'b1; bus_a.a_in = 8'h3C; cycle();
    bus_a.ei = 1'b1; bus_a.insn_done = 1'b1; cycle();
    bus_a.insn_done = 1'b1; cycle();
    bus_a.ld_a_r = 1'b1; bus_a.int_ack = 1'b1; bus_a.f_in = 8'h00;
    expect_af(8'h3C, 8'h04, 8'h00);
    cycle();
    check("quirk_int_iff2", {7'd0, bus_a.iff2}, 8'h00);
    bus_a.ei = 1'b1; bus_a.insn_done = 1'b1; cycle();
    bus_a.insn_done = 1'b1; cycle();
    bus_a.ld_a_r = 1'b1; bus_a.nmi_ack = 1'b1;
    expect_af(8'h3C, 8'h04, 8'h00);
    cycle();
    check("quirk_nmi_iff1", {7'd0, bus_a.iff1}, 8'h00);
    check("quirk_nmi_iff2", {7'd0, bus_a.iff2}, 8'h01);

    // Reset while an af_valid pulse is out drops it and clears state.
    bus_a.ld_i_a = 1'b1; bus_a.a_in = 8'h5A; cycle();
    bus_a.ei = 1'b1; bus_a.insn_done = 1'b1; cycle();
    bus_a.ld_a_i = 1'b1; cycle();
    check("pre_reset_af_valid", {7'd0, bus_a.af_valid}, 8'h01);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_af_valid", {7'd0, bus_a.af_valid}, 8'h00);
    check("mid_rst_reg_i", bus_a.reg_i, 8'h00);
    check("mid_rst_reg_r", bus_a.reg_r, 8'h00);
    check("mid_rst_iff1", {7'd0, bus_a.iff1}, 8'h00);
    check("mid_rst_a_out", bus_a.a_out, 8'h00);
    check("mid_rst_f_out", bus_a.f_out, 8'h00);
    step();
    reset = 1'b0;
    step();
    step();

    check("sb_a_drained", 8'(q_a.size()), 8'h00);
    check("sb_b_drained", 8'(q_b.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
